ahb_apb_xfer_ctrl: RTL and testbench
====================================

Name: ahb_apb_xfer_ctrl

Overview:
AHB-Lite slave-side controller that sequences single AHB transfers onto the APB peripheral bus. It captures the address phase and the write data. It pads write data to 32 bits by transfer size (unused upper bits forced to 1), then drives the APB SETUP/ACCESS phases. It stalls the AHB master via HREADYOUT and returns OKAY, ERROR (PSLVERR) or timeout-ERROR responses. It sits between the AHB interconnect and the APB peripheral set, replacing the stand-alone length-decode path with a full transfer sequencer.

Parameters:
ADDR_W, 32, address width on HADDR/PADDR
TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort; 0 disables timeout

Ports:
HCLK  in  1  system clock, all logic on rising edge
HRESET  in  1  synchronous reset, active-high
HSEL  in  1  slave select
HTRANS  in  2  AHB transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HWRITE  in  1  1 = write
HSIZE  in  3  0=byte, 1=half, 2=word, others treated as byte
HADDR  in  ADDR_W  transfer address
HWDATA  in  32  write data, valid in data phase
HREADY  in  1  bus-wide ready (address phase accepted only when high)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  32  read data
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  32  APB write data (size-padded)
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error, sampled only with PREADY in ACCESS

Behaviour:
- Reset (sync, HRESET=1 at edge): state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HRDATA=0, HRESP=0, HREADYOUT=1; timeout counter=0. Reset mid-transfer aborts at that edge with no response; the master must be reset too.
- Accept: HSEL & HTRANS[1] & HREADY while HREADYOUT=1 (states IDLE, DONE, ERR2). Capture HADDR, HWRITE, HSIZE. Write -> WDATA; read -> SETUP. HTRANS IDLE/BUSY: no transfer, OKAY, HREADYOUT stays 1.
- WDATA (1 cycle): HREADYOUT=0; latch HWDATA through the sizer into PWDATA. Byte: [7:0] data, [31:8] = 1s. Half: [15:0] data, [31:16] = 1s. Word: full. HSIZE 3..7: byte rule. -> SETUP.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE from captured values; HREADYOUT=0. -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
  - PREADY & !PSLVERR -> DONE; HRDATA <= PRDATA on reads, held on writes.
  - PREADY & PSLVERR -> ERR1.
  - !PREADY: counter increments. When counter reaches TIMEOUT-1 with PREADY still low (TIMEOUT>0) -> ERR1, i.e. abort after TIMEOUT ACCESS cycles. Counter clears on leaving ACCESS.
- DONE (1 cycle): PSEL=PENABLE=0, HREADYOUT=1, HRESP=0. Back-to-back accept allowed; otherwise -> IDLE.
- ERR1: HRESP=1, HREADYOUT=0, PSEL=PENABLE=0. -> ERR2.
- ERR2: HRESP=1, HREADYOUT=1 (two-cycle AHB error). Accept allowed; otherwise -> IDLE.
- Latency with zero-wait APB: write accept C0 -> HREADYOUT=1 at C4; read accept C0 -> HREADYOUT=1 at C3. Each PREADY-low cycle adds one.
- PWDATA keeps its last value during reads and idle. HRDATA holds until the next read completes.
- PSEL never asserts outside SETUP/ACCESS. PENABLE never asserts without PSEL.

Decomposition:
- Package ahb_apb_pkg:
  - state enum {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2}
  - HTRANS constants; HSIZE constants (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2)
  - HRESP_OKAY/HRESP_ERROR
- One combinational sub-module, apb_wdata_sizer: HSIZE + raw 32-bit data -> padded 32-bit word.

Test Plan:
- Word write HADDR=0x40, HWDATA=0xDEADBEEF, PREADY=1 -> PSEL rises C2, PENABLE C3, PWDATA=0xDEADBEEF, HREADYOUT=1 C4, HRESP=0.
- Byte write HWDATA=0x123456A5, HSIZE=0 -> PWDATA=0xFFFFFFA5. Half write -> 0xFFFF56A5. HSIZE=5 -> 0xFFFFFFA5.
- Read, PREADY low 3 ACCESS cycles, PRDATA=0x0BADF00D -> HREADYOUT=1 three cycles later than zero-wait, HRDATA=0x0BADF00D.
- Write, PREADY=1 & PSLVERR=1 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then IDLE with HRESP=0.
- PREADY held low, TIMEOUT=16 -> abort after 16 ACCESS cycles, PSEL drops, two-cycle ERROR. TIMEOUT=0 -> waits indefinitely.
- Back-to-back NONSEQ in DONE accepted without idle gap; HRESET asserted during ACCESS -> next edge PSEL=0, PENABLE=0, HREADYOUT=1.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared types and encodings for the AHB-Lite to APB transfer controller.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    ACCESS,
    DONE,
    ERR1,
    ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_apb_xfer_ctrl_if.sv
// AHB-Lite slave and APB requester signals of the transfer controller.
interface ahb_apb_xfer_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              HSEL;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [ADDR_W-1:0] HADDR;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  // The controller: AHB slave side and APB requester side.
  modport slave (
    input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  // The environment: AHB master plus the APB peripheral it reaches.
  modport master (
    output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_wdata_sizer.sv
// Pads AHB write data to a 32-bit APB word; lanes above the transfer size read as 1s.
module apb_wdata_sizer
  import ahb_apb_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);
  // Unsupported sizes (3..7) fall back to the byte rule.
  always_comb begin
    case (size)
      SZ_HALF: data_out = {16'hFFFF, data_in[15:0]};
      SZ_WORD: data_out = data_in;
      default: data_out = {24'hFF_FFFF, data_in[7:0]};
    endcase
  end
endmodule

// File: rtl/ahb_apb_xfer_ctrl.sv
// AHB-Lite to APB transfer sequencer: one AHB transfer at a time, stalls the master
// with HREADYOUT and maps PSLVERR or an ACCESS timeout to a two-cycle ERROR response.
module ahb_apb_xfer_ctrl
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic                HCLK,
  input logic                HRESET,
  ahb_apb_xfer_ctrl_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [2:0]        size_q;
  logic [31:0]       pwdata_q;
  logic [31:0]       hrdata_q;
  logic [31:0]       wdata_sized;
  logic              addr_valid;
  logic              timed_out;
  logic              psel, penable, hreadyout, hresp;

  apb_wdata_sizer u_sizer (
    .size     (size_q),
    .data_in  (bus.HWDATA),
    .data_out (wdata_sized)
  );

  assign addr_valid = bus.HSEL && bus.HREADY &&
                      (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
  assign timed_out  = (TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state)
      IDLE, DONE, ERR2: begin
        hresp = (state == ERR2) ? HRESP_ERROR : HRESP_OKAY;
        if (addr_valid) state_nxt = bus.HWRITE ? WDATA : SETUP;
        else            state_nxt = IDLE;
      end
      WDATA: begin
        hreadyout = 1'b0;
        state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        hreadyout = 1'b0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        hreadyout = 1'b0;
        // PREADY wins over the timeout on the last permitted cycle.
        if (bus.PREADY)     state_nxt = bus.PSLVERR ? ERR1 : DONE;
        else if (timed_out) state_nxt = ERR1;
      end
      ERR1: begin
        hresp     = HRESP_ERROR;
        hreadyout = 1'b0;
        state_nxt = ERR2;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (HRESET) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      size_q   <= SZ_BYTE;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (hreadyout && addr_valid) begin
        paddr_q  <= bus.HADDR;
        pwrite_q <= bus.HWRITE;
        size_q   <= bus.HSIZE;
      end
      if (state == WDATA) pwdata_q <= wdata_sized;
      if (state == ACCESS && bus.PREADY && !bus.PSLVERR && !pwrite_q) hrdata_q <= bus.PRDATA;
      tmo_cnt <= (state == ACCESS && state_nxt == ACCESS) ? tmo_cnt + CNT_W'(1) : '0;
    end
  end

  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata_q;
endmodule

// File: tb/tb_ahb_apb_xfer_ctrl.sv
// Randomized bench for ahb_apb_xfer_ctrl: transfers are predicted from latency and
// padding rules; a second instance with the timeout disabled shares the inputs.
`timescale 1ns/1ps
module tb_ahb_apb_xfer_ctrl;
  import ahb_apb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int TMO    = 16;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_apb_xfer_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  ahb_apb_xfer_ctrl_if #(.ADDR_W(ADDR_W)) bus_nt ();

  assign bus_nt.HSEL    = bus.HSEL;
  assign bus_nt.HTRANS  = bus.HTRANS;
  assign bus_nt.HWRITE  = bus.HWRITE;
  assign bus_nt.HSIZE   = bus.HSIZE;
  assign bus_nt.HADDR   = bus.HADDR;
  assign bus_nt.HWDATA  = bus.HWDATA;
  assign bus_nt.HREADY  = bus.HREADY;
  assign bus_nt.PRDATA  = bus.PRDATA;
  assign bus_nt.PREADY  = bus.PREADY;
  assign bus_nt.PSLVERR = bus.PSLVERR;

  ahb_apb_xfer_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  ahb_apb_xfer_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(0)) dut_nt (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus_nt)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pwdata;
  logic [31:0] exp_hrdata;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Bytes kept = 1 << size for sizes 0..2, one byte otherwise; the rest reads as 1s.
  function automatic logic [31:0] pad(input logic [2:0] sz, input logic [31:0] d);
    int          nbytes;
    logic [31:0] keep;
    nbytes = (sz < 3'd3) ? (1 << sz) : 1;
    keep   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    return (d & keep) | ~keep;
  endfunction

  task automatic drive_idle_inputs();
    bus.HSEL    = 1'($urandom);
    bus.HTRANS  = 2'($urandom);
    bus.HREADY  = (bus.HSEL && bus.HTRANS[1]) ? 1'b0 : 1'($urandom);
    bus.HWRITE  = 1'($urandom);
    bus.HSIZE   = 3'($urandom);
    bus.HADDR   = $urandom;
    bus.HWDATA  = $urandom;
    bus.PREADY  = 1'($urandom);
    bus.PSLVERR = 1'($urandom);
    bus.PRDATA  = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive_idle_inputs();
      @(negedge HCLK);
      check("idle_hreadyout", 64'(bus.HREADYOUT), 64'(1));
      check("idle_hresp", 64'(bus.HRESP), 64'(0));
      check("idle_psel", 64'(bus.PSEL), 64'(0));
      check("idle_penable", 64'(bus.PENABLE), 64'(0));
    end
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    drive_idle_inputs();
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET     = 1'b0;
    exp_pwdata = '0;
    exp_hrdata = '0;
  endtask

  // One transfer starting in the current (ready) cycle; returns with the DUT in its
  // final ready cycle (DONE or ERR2) so the caller may issue the next transfer back-to-back.
  task automatic do_xfer(input bit w, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int nwait, input bit err, output logic [31:0] obs_pwdata);
    bit tmo, is_err, rdy, finished;
    int acc, done_idx, psel_idx, idx, acc_seen, first_psel, first_pen;
    tmo        = (nwait >= TMO);
    is_err     = tmo || err;
    acc        = tmo ? TMO : nwait + 1;
    done_idx   = (w ? 1 : 0) + 1 + acc + (is_err ? 2 : 1);
    psel_idx   = w ? 2 : 1;
    if (w) exp_pwdata = pad(sz, wd);
    obs_pwdata = '0;
    idx = 0; acc_seen = 0; first_psel = -1; first_pen = -1; finished = 1'b0;

    check("c0_hreadyout", 64'(bus.HREADYOUT), 64'(1));
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = w; bus.HSIZE = sz;
    bus.HADDR = addr; bus.HREADY = 1'b1; bus.HWDATA = $urandom;
    bus.PREADY = 1'($urandom); bus.PSLVERR = 1'($urandom); bus.PRDATA = $urandom;

    while (idx < done_idx + 8) begin
      @(negedge HCLK);
      idx++;
      if (bus.PENABLE) check("penable_without_psel", 64'(bus.PSEL), 64'(1));
      if (bus.PSEL) begin
        if (first_psel < 0) first_psel = idx;
        check("paddr", 64'(bus.PADDR), 64'(addr));
        check("pwrite", 64'(bus.PWRITE), 64'(w));
        check("pwdata", 64'(bus.PWDATA), 64'(exp_pwdata));
        obs_pwdata = bus.PWDATA;
      end
      if (bus.PSEL && bus.PENABLE) begin
        if (first_pen < 0) first_pen = idx;
        acc_seen++;
      end
      if (bus.HREADYOUT) begin
        finished = 1'b1;
        break;
      end
      check("hresp_stalled", 64'(bus.HRESP), 64'(is_err && idx == done_idx - 1));
      // Junk address phase while stalled; HWDATA is only valid in the first data cycle.
      bus.HSEL = 1'($urandom); bus.HTRANS = 2'($urandom); bus.HREADY = 1'b0;
      bus.HADDR = $urandom; bus.HWRITE = 1'($urandom); bus.HSIZE = 3'($urandom);
      bus.HWDATA = (idx == 1) ? wd : $urandom;
      if (bus.PSEL && bus.PENABLE) begin
        rdy         = (acc_seen > nwait);
        bus.PREADY  = rdy;
        bus.PSLVERR = rdy ? err : 1'($urandom);
        bus.PRDATA  = rdy ? rd : $urandom;
      end else begin
        bus.PREADY = 1'($urandom); bus.PSLVERR = 1'($urandom); bus.PRDATA = $urandom;
      end
    end

    check("xfer_completed", 64'(finished), 64'(1));
    check("done_cycle", 64'(idx), 64'(done_idx));
    check("first_psel_cycle", 64'(first_psel), 64'(psel_idx));
    check("first_penable_cycle", 64'(first_pen), 64'(psel_idx + 1));
    check("access_cycles", 64'(acc_seen), 64'(acc));
    check("hresp_final", 64'(bus.HRESP), 64'(is_err));
    check("psel_final", 64'(bus.PSEL), 64'(0));
    if (!w && !is_err) exp_hrdata = rd;
    check("hrdata", 64'(bus.HRDATA), 64'(exp_hrdata));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [31:0] obs;
    int          held, waited;

    do_reset();
    check("rst_psel", 64'(bus.PSEL), 64'(0));
    check("rst_penable", 64'(bus.PENABLE), 64'(0));
    check("rst_pwrite", 64'(bus.PWRITE), 64'(0));
    check("rst_paddr", 64'(bus.PADDR), 64'(0));
    check("rst_pwdata", 64'(bus.PWDATA), 64'(0));
    check("rst_hrdata", 64'(bus.HRDATA), 64'(0));
    check("rst_hresp", 64'(bus.HRESP), 64'(0));
    check("rst_hreadyout", 64'(bus.HREADYOUT), 64'(1));

    idle(3);
    do_xfer(1'b1, SZ_WORD, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, obs);
    check("word_pwdata", 64'(obs), 64'h0000_0000_DEAD_BEEF);
    // Back-to-back from DONE with no idle gap.
    do_xfer(1'b1, SZ_BYTE, 32'h44, 32'h1234_56A5, 32'h0, 0, 1'b0, obs);
    check("byte_pwdata", 64'(obs), 64'h0000_0000_FFFF_FFA5);
    do_xfer(1'b1, SZ_HALF, 32'h48, 32'h1234_56A5, 32'h0, 1, 1'b0, obs);
    check("half_pwdata", 64'(obs), 64'h0000_0000_FFFF_56A5);
    idle(2);
    do_xfer(1'b1, 3'd5, 32'h4C, 32'h1234_56A5, 32'h0, 0, 1'b0, obs);
    check("size5_pwdata", 64'(obs), 64'h0000_0000_FFFF_FFA5);
    idle(1);
    do_xfer(1'b0, SZ_WORD, 32'h50, 32'h0, 32'h0BAD_F00D, 3, 1'b0, obs);
    check("read_hrdata", 64'(bus.HRDATA), 64'h0000_0000_0BAD_F00D);
    idle(1);
    do_xfer(1'b1, SZ_WORD, 32'h54, 32'hCAFE_0001, 32'h0, 0, 1'b1, obs);
    idle(1);
    do_xfer(1'b0, SZ_WORD, 32'h58, 32'h0, 32'h5555_AAAA, TMO - 1, 1'b0, obs);
    do_xfer(1'b0, SZ_WORD, 32'h5C, 32'h0, 32'h7777_7777, TMO + 10, 1'b0, obs);
    idle(1);

    do_reset();
    for (int t = 0; t < 60; t++) begin
      int r, nw;
      r = int'($urandom_range(9, 0));
      if (r < 6)      nw = int'($urandom_range(3, 0));
      else if (r < 9) nw = int'($urandom_range(8, 4));
      else            nw = TMO - 1 + int'($urandom_range(2, 0));
      do_xfer(1'($urandom), 3'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
              nw, ($urandom_range(5, 0) == 0), obs);
      if ($urandom_range(2, 0) == 0) idle(int'($urandom_range(2, 1)));
    end
    idle(1);

    // TIMEOUT=0 instance must keep waiting while the TIMEOUT=16 one aborts.
    do_reset();
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b0; bus.HSIZE = SZ_WORD;
    bus.HADDR = 32'h100; bus.HREADY = 1'b1; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HREADY = 1'b0;
    held = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      if (bus_nt.PSEL && bus_nt.PENABLE && !bus_nt.HREADYOUT) held++;
    end
    check("nt_access_held", 64'(held), 64'(40));
    bus.PREADY = 1'b1; bus.PRDATA = 32'h1234_5678;
    @(negedge HCLK);
    check("nt_hreadyout", 64'(bus_nt.HREADYOUT), 64'(1));
    check("nt_hresp", 64'(bus_nt.HRESP), 64'(0));
    check("nt_hrdata", 64'(bus_nt.HRDATA), 64'h0000_0000_1234_5678);
    check("tmo_hrdata_held", 64'(bus.HRDATA), 64'(0));

    // Reset in the middle of ACCESS.
    do_reset();
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b0; bus.HSIZE = SZ_WORD;
    bus.HADDR = 32'h80; bus.HREADY = 1'b1; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HREADY = 1'b0;
    waited = 0;
    while (!(bus.PSEL && bus.PENABLE) && waited < 5) begin
      @(negedge HCLK);
      waited++;
    end
    check("reached_access", 64'(bus.PSEL && bus.PENABLE), 64'(1));
    HRESET = 1'b1;
    @(negedge HCLK);
    check("rst_access_psel", 64'(bus.PSEL), 64'(0));
    check("rst_access_penable", 64'(bus.PENABLE), 64'(0));
    check("rst_access_hreadyout", 64'(bus.HREADYOUT), 64'(1));
    check("rst_access_hresp", 64'(bus.HRESP), 64'(0));
    HRESET = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
